// File: rtl/dmem_lsu_pkg.sv
// Shared encodings and decode helpers for the data-memory load/store unit.
package dmem_lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0011;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1011;

  typedef logic [1:0] op_size_t;
  localparam op_size_t SZ_BYTE = 2'b00;
  localparam op_size_t SZ_HALF = 2'b01;
  localparam op_size_t SZ_WORD = 2'b11;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_LOAD  = 3'd1;
  localparam state_t ST_MERGE = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_RESP  = 3'd4;

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Size lives in the low opcode bits for every legal op.
  function automatic op_size_t op_size(input logic [3:0] op);
    return op[1:0];
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Pipeline-side request/response channel and memory-side bus of the LSU.
interface dmem_lsu_if;
  import dmem_lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [3:0]      req_op;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (output req_valid, req_op, req_addr, req_wdata, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave  (input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

interface dmem_mem_if;
  import dmem_lsu_pkg::*;

  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/dmem_lsu_align.sv
// Big-endian lane extract/extend for loads and lane merge for sub-word stores.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  op_size_t    size,
  input  logic        uns,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane; offset 0 is the most significant byte.
  always_comb begin
    byte_s = 8'h00;
    case (off)
      2'd0:    byte_s = word[31:24];
      2'd1:    byte_s = word[23:16];
      2'd2:    byte_s = word[15:8];
      2'd3:    byte_s = word[7:0];
      default: byte_s = 8'h00;
    endcase
    if (off[1]) begin
      half_s = word[15:0];
    end else begin
      half_s = word[31:16];
    end
  end

  // Extend the selected lane for loads.
  always_comb begin
    load_data = 32'h0000_0000;
    case (size)
      SZ_BYTE: load_data = {{24{~uns & byte_s[7]}}, byte_s};
      SZ_HALF: load_data = {{16{~uns & half_s[15]}}, half_s};
      SZ_WORD: load_data = word;
      default: load_data = word;
    endcase
  end

  // Overwrite only the addressed lane for stores.
  always_comb begin
    merge_data = word;
    case (size)
      SZ_BYTE: begin
        case (off)
          2'd0:    merge_data[31:24] = wdata[7:0];
          2'd1:    merge_data[23:16] = wdata[7:0];
          2'd2:    merge_data[15:8]  = wdata[7:0];
          2'd3:    merge_data[7:0]   = wdata[7:0];
          default: merge_data = word;
        endcase
      end
      SZ_HALF: begin
        if (off[1]) begin
          merge_data[15:0] = wdata;
        end else begin
          merge_data[31:16] = wdata;
        end
      end
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the word-wide data memory: FSM, request/response
// registers and error checks; sub-word stores are done as read-modify-write.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = XLEN
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_lsu_if.slave  bus,
  dmem_mem_if.master mem
);

  state_t              state_r;
  op_size_t            size_r;
  logic                uns_r;
  logic [1:0]          off_r;
  logic [15:0]         wdata_r;
  logic [DATA_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   rsp_rdata_r;
  logic                rsp_err_r;
  logic                err_s;
  logic [DATA_W-1:0]   load_data_s;
  logic [DATA_W-1:0]   merge_data_s;

  // Request screening: illegal op beats misalignment beats range.
  always_comb begin
    err_s = 1'b0;
    if (!(is_load(bus.req_op) || is_store(bus.req_op))) begin
      err_s = 1'b1;
    end else if ((op_size(bus.req_op) == SZ_WORD) && (bus.req_addr[1:0] != 2'b00)) begin
      err_s = 1'b1;
    end else if ((op_size(bus.req_op) == SZ_HALF) && bus.req_addr[0]) begin
      err_s = 1'b1;
    end else if (|bus.req_addr[31:ADDR_W+2]) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
  end

  dmem_lsu_align u_align (
    .word       (mem.mem_rdata),
    .off        (off_r),
    .size       (size_r),
    .uns        (uns_r),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // Main FSM with request and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      size_r      <= SZ_BYTE;
      uns_r       <= 1'b0;
      off_r       <= 2'b00;
      wdata_r     <= 16'h0000;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rsp_rdata_r <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid) begin
            size_r      <= op_size(bus.req_op);
            uns_r       <= bus.req_op[2];
            off_r       <= bus.req_addr[1:0];
            wdata_r     <= bus.req_wdata[15:0];
            mem_addr_r  <= {{(DATA_W-ADDR_W){1'b0}}, bus.req_addr[ADDR_W+1:2]};
            rsp_rdata_r <= '0;
            rsp_err_r   <= err_s;
            if (err_s) begin
              state_r <= ST_RESP;
            end else if (is_load(bus.req_op)) begin
              state_r <= ST_LOAD;
            end else if (bus.req_op == OP_SW) begin
              mem_wdata_r <= bus.req_wdata;
              state_r     <= ST_WRITE;
            end else begin
              state_r <= ST_MERGE;
            end
          end
        end
        ST_LOAD: begin
          rsp_rdata_r <= load_data_s;
          state_r     <= ST_RESP;
        end
        ST_MERGE: begin
          mem_wdata_r <= merge_data_s;
          state_r     <= ST_WRITE;
        end
        ST_WRITE: begin
          rsp_rdata_r <= '0;
          rsp_err_r   <= 1'b0;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Handshake and write strobe come straight from the state register.
  assign bus.req_ready = (state_r == ST_IDLE);
  assign bus.rsp_valid = (state_r == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign mem.mem_we    = (state_r == ST_WRITE);
  assign mem.mem_addr  = mem_addr_r;
  assign mem.mem_wdata = mem_wdata_r;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a 64-word behavioural data memory.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          we_cnt;
  } exp_t;

  logic clk;
  logic rst_n;
  logic mem_clr;
  int   checks;
  int   errors;
  exp_t sb_q[$];
  logic [31:0] mem_arr [0:63];
  logic [31:0] last_we_addr;
  logic [31:0] last_we_data;

  dmem_lsu_if bus ();
  dmem_mem_if mbus ();

  dmem_lsu #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mem   (mbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
    end else if (mbus.mem_we) begin
      mem_arr[mbus.mem_addr[5:0]] <= mbus.mem_wdata;
    end
  end
  assign mbus.mem_rdata = mem_arr[mbus.mem_addr[5:0]];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  // One request/response transaction; expectations go through the scoreboard.
  task automatic run(input string tag, input logic [3:0] op, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat, input int exp_we, input int stall);
    exp_t e;
    exp_t got;
    int   lat;
    int   we_cnt;
    logic seen;
    logic [31:0] held;
    got.rdata = 32'h0;
    got.err = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.rsp_ready = (stall == 0);
    check_eq({tag, "_ready"}, {31'h0, bus.req_ready}, 32'h1);
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat; e.we_cnt = exp_we;
    sb_q.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 0; we_cnt = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (mbus.mem_we) begin
        we_cnt++;
        last_we_addr = mbus.mem_addr;
        last_we_data = mbus.mem_wdata;
      end
      if (bus.rsp_valid) seen = 1'b1;
    end
    e = sb_q.pop_front();
    check_eq({tag, "_rsp_seen"}, {31'h0, seen}, 32'h1);
    check_eq({tag, "_rdata"}, bus.rsp_rdata, e.rdata);
    check_eq({tag, "_err"}, {31'h0, bus.rsp_err}, {31'h0, e.err});
    check_eq({tag, "_lat"}, lat, e.lat);
    check_eq({tag, "_we_cnt"}, we_cnt, e.we_cnt);
    check_eq({tag, "_busy"}, {31'h0, bus.req_ready}, 32'h0);
    if (stall > 0) begin
      held = bus.rsp_rdata;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check_eq({tag, "_stall_valid"}, {31'h0, bus.rsp_valid}, 32'h1);
        check_eq({tag, "_stall_rdata"}, bus.rsp_rdata, held);
        check_eq({tag, "_stall_ready"}, {31'h0, bus.req_ready}, 32'h0);
        check_eq({tag, "_stall_we"}, {31'h0, mbus.mem_we}, 32'h0);
      end
      bus.rsp_ready = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_done_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
    check_eq({tag, "_done_ready"}, {31'h0, bus.req_ready}, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, {31'h0, bus.req_ready}, 32'h1);
    check_eq({tag, "_rsp_valid"}, {31'h0, bus.rsp_valid}, 32'h0);
    check_eq({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    check_eq({tag, "_rsp_err"}, {31'h0, bus.rsp_err}, 32'h0);
    check_eq({tag, "_mem_we"}, {31'h0, mbus.mem_we}, 32'h0);
    check_eq({tag, "_mem_addr"}, mbus.mem_addr, 32'h0);
    check_eq({tag, "_mem_wdata"}, mbus.mem_wdata, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    mem_clr = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op = 4'h0;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    mem_clr = 1'b0;
    rst_n = 1'b1;

    run("sw10", OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 0);
    check_eq("sw10_we_addr", last_we_addr, 32'h4);
    check_eq("sw10_we_data", last_we_data, 32'hDEADBEEF);
    run("lw10", OP_LW, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 0);
    run("sb11", OP_SB, 32'h11, 32'h55, 32'h0, 1'b0, 3, 1, 0);
    check_eq("sb11_mem", mem_arr[4], 32'hDE55BEEF);
    run("lb11", OP_LB, 32'h11, 32'h0, 32'h00000055, 1'b0, 2, 0, 0);
    run("lbu10", OP_LBU, 32'h10, 32'h0, 32'h000000DE, 1'b0, 2, 0, 0);
    run("lb10", OP_LB, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 2, 0, 0);
    run("sh12", OP_SH, 32'h12, 32'hFFFF8001, 32'h0, 1'b0, 3, 1, 0);
    check_eq("sh12_mem", mem_arr[4], 32'hDE558001);
    run("lh12", OP_LH, 32'h12, 32'h0, 32'hFFFF8001, 1'b0, 2, 0, 0);
    run("lhu12", OP_LHU, 32'h12, 32'h0, 32'h00008001, 1'b0, 2, 0, 0);
    run("lh10", OP_LH, 32'h10, 32'h0, 32'hFFFFDE55, 1'b0, 2, 0, 0);
    run("sb13", OP_SB, 32'h13, 32'h123456AB, 32'h0, 1'b0, 3, 1, 0);
    check_eq("sb13_mem", mem_arr[4], 32'hDE5580AB);
    run("lbu13", OP_LBU, 32'h13, 32'h0, 32'h000000AB, 1'b0, 2, 0, 0);
    run("lb12", OP_LB, 32'h12, 32'h0, 32'hFFFFFF80, 1'b0, 2, 0, 0);
    run("lw13", OP_LW, 32'h13, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    run("sh11", OP_SH, 32'h11, 32'hAAAA, 32'h0, 1'b1, 1, 0, 0);
    run("op2", 4'b0010, 32'h10, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    run("lw100", OP_LW, 32'h100, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    run("sw_oor", OP_SW, 32'h400, 32'h11111111, 32'h0, 1'b1, 1, 0, 0);
    check_eq("err_mem_intact", mem_arr[4], 32'hDE5580AB);
    run("lw_stall", OP_LW, 32'h10, 32'h0, 32'hDE5580AB, 1'b0, 2, 0, 5);

    // Cut a SW inside its WRITE cycle.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op = OP_SW;
    bus.req_addr = 32'h20;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    check_eq("rstw_we_before", {31'h0, mbus.mem_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("rstw");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rstw_mem8", mem_arr[8], 32'h0);
    check_reset_outputs("rstw_rel");
    run("lw20", OP_LW, 32'h20, 32'h0, 32'h0, 1'b0, 2, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator that drives the word-wide, synchronous-write, asynchronous-read data memory of the MIPS core. Accepts one byte/halfword/word load or store per handshake from the execute/memory stage, converts byte addresses to word indices, performs sign/zero extension for loads, and performs read-modify-write for sub-word stores, since the memory only writes whole words. Sits between the pipeline's memory stage and the data memory; it is the memory's only master.

## Interface
- ADDR_W, 6, word-index width of the attached memory (2**ADDR_W words)
- DATA_W, 32, data width; fixed at 32, other values unsupported

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  4  opcode[3:0]: LB=0000, LH=0001, LW=0011, LBU=0100, LHU=0101, SB=1000, SH=1001, SW=1011
- req_addr  in  32  byte address
- req_wdata  in  32  store data; sub-word stores use low bits
- rsp_valid  out  1  response present
- rsp_ready  in  1  pipeline accepts response
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range, or illegal op
- mem_we  out  1  memory write enable
- mem_addr  out  32  word index, zero-extended
- mem_wdata  out  32  write word
- mem_rdata  in  32  asynchronous read data for mem_addr

## Operation
- Big-endian byte lanes: byte offset 0 = bits 31:24, offset 3 = bits 7:0; halfword offset 0 = bits 31:16.
- States: IDLE, LOAD, MERGE, WRITE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch op, address, and data; mem_addr <= req_addr[ADDR_W+1:2].
  - Error check, in priority order: illegal op; misalignment (LW/SW: addr[1:0]!=0; LH/LHU/SH: addr[0]!=0); out of range (req_addr[31:ADDR_W+2]!=0). On error: go to RESP with rsp_err=1, rsp_rdata=0, no memory access.
  - Otherwise: loads go to LOAD, SW goes to WRITE with mem_wdata=req_wdata, SB/SH go to MERGE.
- LOAD: capture mem_rdata, extract the lane, extend it (LB/LH sign, LBU/LHU zero), then go to RESP.
- MERGE: capture mem_rdata, replace the addressed lane with req_wdata[7:0] or [15:0] to form mem_wdata, keep other lanes, then go to WRITE.
- WRITE: mem_we=1 for exactly one cycle; the memory commits at the closing edge. Then go to RESP with rsp_rdata=0, rsp_err=0.
- RESP: rsp_valid=1 and held stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE. req_ready=0 in every state except IDLE.
- mem_we is decoded from the state register only; it is never combinational from inputs.

## Timing
- Reset values: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Latency is counted from the accept edge (E) to the first cycle with rsp_valid:
  - error: 1 cycle
  - load: 2 cycles
  - SW: 2 cycles
  - SB/SH: 3 cycles
- Next accept is possible in the cycle after the response handshake, so there is no request/response overlap.
- rsp_ready held low stalls indefinitely in RESP with all response outputs stable.
- Reset mid-operation: state returns to IDLE immediately and mem_we drops asynchronously. A store whose WRITE cycle is cut by reset before its edge does not commit. Any pending response is discarded.
- MERGE and WRITE of one store are back-to-back with no intervening access, so the read-modify-write is atomic (the block is the sole master).

## Structure
- Package dmem_lsu_pkg: op encodings, state enum, and helpers is_load/is_store/op_size.
- Sub-module dmem_lsu_align (combinational): lane extract plus extension for loads, lane merge for stores. It is shared by LOAD and MERGE.
- Top module holds the FSM, request/response registers, and error checks.

## Test plan
- SW addr 0x10, data 0xDEADBEEF, then LW 0x10: mem_we pulse with mem_addr=4, mem_wdata=0xDEADBEEF; load returns 0xDEADBEEF, rsp_err=0, rsp_valid at E+2.
- With word 4 = 0xDEADBEEF: SB addr 0x11, data 0x55 → word becomes 0xDE55BEEF (MERGE then WRITE, rsp at E+3). Then LB 0x11 → 0x00000055. Then LBU 0x10 → 0x000000DE. Then LB 0x10 → 0xFFFFFFDE.
- SH addr 0x12, data 0x8001 on word 0xDE55BEEF → 0xDE558001. Then LH 0x12 → 0xFFFF8001. Then LHU 0x12 → 0x00008001.
- Errors:
  - LW 0x13 → rsp_err=1 at E+1, mem_we never asserted.
  - SH 0x11 → error.
  - req_op=0010 → error.
  - LW 0x100 with ADDR_W=6 → error.
- Backpressure: hold rsp_ready=0 for 5 cycles after LW → rsp_valid/rsp_rdata stable, req_ready=0, no further mem_we; accept resumes the cycle after the handshake.
- Assert rst_n=0 during the WRITE cycle of SW 0x20 data 0x12345678 → mem_we falls immediately, word 8 unchanged, all outputs at reset values, req_ready=1 after release.
